line_buff_sys: RTL and testbench
================================

// Module: line_buff_sys
// PURPOSE
//  Ping-pong tile line buffer between the frame buffer and the VGA pixel path.
//  It fetches one tile-line (TILE_WIDTH x TILE_WIDTH tiles) from a 1-cycle-latency sync-read frame buffer into one of two register buffers.
//  It drives the displayed pixel combinationally from the active buffer, indexed by the VGA pixel/line counters.
// PARAMETERS
//  WIDTH_PX          640  active pixels per line
//  HEIGHT_LNS        480  active lines per frame
//  H_B_PORCH_MAX_PX  144  first active pixel-counter value (sync+back porch)
//  V_B_PORCH_MAX_LNS 35   first active line-counter value
//  TILE_WIDTH        4    tile edge in pixels (tile = TILE_WIDTH x TILE_WIDTH, one colour)
//  PXL_WIDTH         12   bits per tile colour (RGB 4:4:4)
//  TILES_PER_ROW     5    tiles packed per frame-buffer word
//  PXL_CTR_WIDTH     10 / LN_CTR_WIDTH 10  counter input widths
//  FBUFF_ADDR_WIDTH  12 / FBUFF_DATA_WIDTH 60 (=TILES_PER_ROW*PXL_WIDTH)
//  Derived: TPL=WIDTH_PX/TILE_WIDTH=160 tiles/line; RPL=TPL/TILES_PER_ROW=32 words/tile-line; NTL=HEIGHT_LNS/TILE_WIDTH=120 tile-lines
// PORTS
//  clk_i         in   1                 pixel clock
//  rst_i         in   1                 reset, asynchronous, active-high
//  pxl_cntr_i    in   PXL_CTR_WIDTH     horizontal counter (0..799)
//  ln_cntr_i     in   LN_CTR_WIDTH      vertical counter (0..524)
//  fbuff_data_i  in   FBUFF_DATA_WIDTH  frame-buffer read data, valid 1 cycle after en
//  fbuff_addr_o  out  FBUFF_ADDR_WIDTH  frame-buffer read address
//  fbuff_en_o    out  1                 frame-buffer read enable
//  disp_pxl_o    out  PXL_WIDTH         pixel colour for current counters
//  fill_busy_o   out  1                 high while a fill is in progress
// BEHAVIOUR
//  - Memory map: tile (row r, col t) = word r*RPL + t/TILES_PER_ROW, bits [(t%TILES_PER_ROW)*PXL_WIDTH +: PXL_WIDTH].
//  - Buffers: buf[0], buf[1], each TPL x PXL_WIDTH registers. Tile-line k is always held in buf[k%2].
//  - Display region: V_B_PORCH_MAX_LNS<=ln<V_B_PORCH_MAX_LNS+HEIGHT_LNS and H_B_PORCH_MAX_PX<=pxl<H_B_PORCH_MAX_PX+WIDTH_PX.
//    In region: k=(ln-V_B_PORCH_MAX_LNS)/TILE_WIDTH, t=(pxl-H_B_PORCH_MAX_PX)/TILE_WIDTH, disp_pxl_o=buf[k%2][t].
//    The read is combinational (zero latency), so the pixel matches the counters in the same cycle. Outside the region disp_pxl_o=0.
//  - Fill FSM states: IDLE -> READ (RPL cycles, en=1, addr=base+i, i=0..RPL-1) -> LAST (en=0, capture final word) -> IDLE.
//    The word returned for index i is written to slots [i*TILES_PER_ROW +: TILES_PER_ROW] of the target buffer.
//    A fill occupies RPL+1=33 cycles; fill_busy_o is high in READ and LAST.
//  - Prefill: in IDLE at ln==0 && pxl==0, fill buf[0] with tile-line 0 (base 0), then immediately buf[1] with tile-line 1 (base RPL).
//    The two fills run back to back, 66 cycles total.
//  - Refill: at pxl==0 on ln=V_B_PORCH_MAX_LNS+k*TILE_WIDTH, for 1<=k<=NTL-2, fill buf[(k+1)%2] with tile-line k+1 (base (k+1)*RPL).
//  - No refill is issued for k=NTL-1. The address never exceeds NTL*RPL-1=3839. The next frame restarts at the prefill.
//  - A trigger arriving while the FSM is not IDLE is dropped; the display continues from stale buffer contents.
//  - Reset (any time, including mid-fill): FSM=IDLE, fbuff_en_o=0, fbuff_addr_o=0, both buffers cleared to 0, disp_pxl_o=0, fill_busy_o=0.
//    A partial fill is abandoned and is not resumed.
//  - Counter arithmetic uses widths of at least PXL_CTR_WIDTH / LN_CTR_WIDTH. Division by TILE_WIDTH requires TILE_WIDTH to be a power of two.
// CONFIGURATION
//  UNDERRUN_FLAG_EN defined: adds output underrun_o (1 bit). Reset value 0.
//    underrun_o is a sticky flag, cleared only by rst_i.
//    It is set when the first active pixel of a tile-line is displayed while that tile-line's fill has not completed.
//  UNDERRUN_FLAG_EN undefined: the port and its logic are absent; behaviour is otherwise identical.
// TESTING
//  1 Reset: assert rst_i mid-READ -> en=0, addr=0, disp_pxl_o=0 immediately; no en pulses until the next ln=0,pxl=0.
//  2 Prefill: counters reach 0/0 -> addr 0..31 on cycles 1..32, then addr 32..63, busy for 66 cycles.
//  3 Display: word0=tiles 0..4 = 0x000,0x111,0x222,0x333,0x444 -> at ln35 px144..147 disp=0x000; px148 disp=0x111; px143 disp=0.
//  4 Refill: ln39 px0 -> addr 64..95 into buf[0]; at ln39 px144, disp=buf[1][0] (tile-line 1).
//  5 Last tile: ln514 px780..783 -> disp = word 3839 bits[59:48]; no fill issued at ln511 px0.
//  6 Underrun (UNDERRUN_FLAG_EN): hold the FSM busy via a late reset release at ln34 -> underrun_o=1 at ln35 px144 and stays 1.

Source files
------------

// File: rtl/line_buff_sys.sv
// rtl/line_buff_sys.sv - ping-pong tile line buffer between the frame buffer and the VGA pixel path
// Optional feature macro: UNDERRUN_FLAG_EN adds the sticky underrun_o flag.
module line_buff_sys #(
    parameter int WIDTH_PX          = 640,
    parameter int HEIGHT_LNS        = 480,
    parameter int H_B_PORCH_MAX_PX  = 144,
    parameter int V_B_PORCH_MAX_LNS = 35,
    parameter int TILE_WIDTH        = 4,
    parameter int PXL_WIDTH         = 12,
    parameter int TILES_PER_ROW     = 5,
    parameter int PXL_CTR_WIDTH     = 10,
    parameter int LN_CTR_WIDTH      = 10,
    parameter int FBUFF_ADDR_WIDTH  = 12,
    parameter int FBUFF_DATA_WIDTH  = TILES_PER_ROW * PXL_WIDTH
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [PXL_CTR_WIDTH-1:0]    pxl_cntr_i,
    input  logic [LN_CTR_WIDTH-1:0]     ln_cntr_i,
    input  logic [FBUFF_DATA_WIDTH-1:0] fbuff_data_i,
    output logic [FBUFF_ADDR_WIDTH-1:0] fbuff_addr_o,
    output logic                        fbuff_en_o,
    output logic [PXL_WIDTH-1:0]        disp_pxl_o,
    output logic                        fill_busy_o
`ifdef UNDERRUN_FLAG_EN
    ,
    output logic                        underrun_o
`endif
);
    localparam int TPL     = WIDTH_PX / TILE_WIDTH;
    localparam int RPL     = TPL / TILES_PER_ROW;
    localparam int NTL     = HEIGHT_LNS / TILE_WIDTH;
    localparam int TW_LOG2 = $clog2(TILE_WIDTH);
    localparam int TPL_W   = $clog2(TPL);
    localparam int RPL_W   = $clog2(RPL);
    localparam int LINE_W  = $clog2(NTL);

    localparam logic [PXL_CTR_WIDTH-1:0]    H_FIRST  = PXL_CTR_WIDTH'(H_B_PORCH_MAX_PX);
    localparam logic [PXL_CTR_WIDTH-1:0]    H_END    = PXL_CTR_WIDTH'(H_B_PORCH_MAX_PX + WIDTH_PX);
    localparam logic [LN_CTR_WIDTH-1:0]     V_FIRST  = LN_CTR_WIDTH'(V_B_PORCH_MAX_LNS);
    localparam logic [LN_CTR_WIDTH-1:0]     V_END    = LN_CTR_WIDTH'(V_B_PORCH_MAX_LNS + HEIGHT_LNS);
    localparam logic [FBUFF_ADDR_WIDTH-1:0] A_RPL    = FBUFF_ADDR_WIDTH'(RPL);
    localparam logic [RPL_W-1:0]            IDX_LAST = RPL_W'(RPL - 1);
    localparam logic [LINE_W-1:0]           K_MAX    = LINE_W'(NTL - 2);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_LAST} state_t;

    state_t                      r_state;
    logic                        r_en;
    logic                        r_busy;
    logic                        r_chain;
    logic [FBUFF_ADDR_WIDTH-1:0] r_addr;
    logic [RPL_W-1:0]            r_idx;
    logic [LINE_W-1:0]           r_line;
    logic                        r_rd_vld;
    logic [RPL_W-1:0]            r_rd_idx;
    logic                        r_rd_buf;
    logic [PXL_WIDTH-1:0]        r_buf0 [TPL];
    logic [PXL_WIDTH-1:0]        r_buf1 [TPL];

    logic [PXL_CTR_WIDTH-1:0]    w_px_rel;
    logic [LN_CTR_WIDTH-1:0]     w_ln_rel;
    logic [TPL_W-1:0]            w_t;
    logic [LINE_W-1:0]           w_k;
    logic                        w_in_region;
    logic                        w_line_top;
    logic                        w_prefill;
    logic                        w_refill;
    logic                        w_start;
    logic [LINE_W-1:0]           w_start_line;
    logic [PXL_WIDTH-1:0]        w_pxl;

    assign w_px_rel    = pxl_cntr_i - H_FIRST;
    assign w_ln_rel    = ln_cntr_i - V_FIRST;
    assign w_t         = TPL_W'(w_px_rel >> TW_LOG2);
    assign w_k         = LINE_W'(w_ln_rel >> TW_LOG2);
    assign w_in_region = (pxl_cntr_i >= H_FIRST) && (pxl_cntr_i < H_END) &&
                         (ln_cntr_i >= V_FIRST) && (ln_cntr_i < V_END);
    assign w_line_top  = (ln_cntr_i >= V_FIRST) && (ln_cntr_i < V_END) &&
                         (w_ln_rel[TW_LOG2-1:0] == '0);
    assign w_prefill   = (ln_cntr_i == '0) && (pxl_cntr_i == '0);
    assign w_refill    = w_line_top && (pxl_cntr_i == '0) && (w_k != '0) && (w_k <= K_MAX);

    // The second half of the prefill chains straight out of LAST without visiting IDLE.
    assign w_start      = ((r_state == S_IDLE) && (w_prefill || w_refill)) ||
                          ((r_state == S_LAST) && r_chain);
    assign w_start_line = (r_state == S_LAST) ? r_line + 1'b1 :
                          (w_prefill ? '0 : w_k + 1'b1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_chain <= 1'b0;
            r_addr  <= '0;
            r_idx   <= '0;
            r_line  <= '0;
        end else if (w_start) begin
            r_state <= S_READ;
            r_en    <= 1'b1;
            r_busy  <= 1'b1;
            r_chain <= (r_state == S_IDLE) && w_prefill;
            r_idx   <= '0;
            r_line  <= w_start_line;
            r_addr  <= FBUFF_ADDR_WIDTH'(w_start_line) * A_RPL;
        end else begin
            case (r_state)
                S_READ: begin
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == IDX_LAST) begin
                        r_state <= S_LAST;
                        r_en    <= 1'b0;
                    end else begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
                S_LAST: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Read data lags the enable by one cycle, so the write side works off a delayed copy of idx/target.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rd_vld <= 1'b0;
            r_rd_idx <= '0;
            r_rd_buf <= 1'b0;
            for (int i = 0; i < TPL; i++) begin
                r_buf0[i] <= '0;
                r_buf1[i] <= '0;
            end
        end else begin
            r_rd_vld <= r_en;
            r_rd_idx <= r_idx;
            r_rd_buf <= r_line[0];
            if (r_rd_vld) begin
                for (int j = 0; j < TILES_PER_ROW; j++) begin
                    if (r_rd_buf)
                        r_buf1[TPL_W'(int'(r_rd_idx) * TILES_PER_ROW + j)] <= fbuff_data_i[j*PXL_WIDTH +: PXL_WIDTH];
                    else
                        r_buf0[TPL_W'(int'(r_rd_idx) * TILES_PER_ROW + j)] <= fbuff_data_i[j*PXL_WIDTH +: PXL_WIDTH];
                end
            end
        end
    end

    always_comb begin
        w_pxl = '0;
        if (w_in_region)
            w_pxl = w_k[0] ? r_buf1[w_t] : r_buf0[w_t];
    end

    assign disp_pxl_o   = w_pxl;
    assign fbuff_addr_o = r_addr;
    assign fbuff_en_o   = r_en;
    assign fill_busy_o  = r_busy;

`ifdef UNDERRUN_FLAG_EN
    logic [1:0]        r_done_vld;
    logic [LINE_W-1:0] r_done_line [2];
    logic [LINE_W-1:0] r_rd_line;
    logic              r_underrun;

    // Each buffer remembers which tile-line it fully holds; a partial fill leaves it unowned.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_done_vld     <= '0;
            r_done_line[0] <= '0;
            r_done_line[1] <= '0;
            r_rd_line      <= '0;
            r_underrun     <= 1'b0;
        end else begin
            r_rd_line <= r_line;
            if (w_start)
                r_done_vld[w_start_line[0]] <= 1'b0;
            if (r_rd_vld && (r_rd_idx == IDX_LAST)) begin
                r_done_vld[r_rd_buf]  <= 1'b1;
                r_done_line[r_rd_buf] <= r_rd_line;
            end
            if (w_line_top && (pxl_cntr_i == H_FIRST) &&
                !(r_done_vld[w_k[0]] && (r_done_line[w_k[0]] == w_k)))
                r_underrun <= 1'b1;
        end
    end

    assign underrun_o = r_underrun;
`endif

endmodule

// File: tb/tb_line_buff_sys.sv
// tb/tb_line_buff_sys.sv - scoreboard bench for line_buff_sys (fill addresses and displayed pixels)
module tb_line_buff_sys;
    localparam int NL = 1;
    localparam int NP = 1;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [9:0]  pxl;
    logic [9:0]  ln;
    logic [59:0] fdata;
    logic [11:0] faddr;
    logic        fen;
    logic [11:0] disp;
    logic        busy;
`ifdef UNDERRUN_FLAG_EN
    logic        underrun;
`endif

    int checks = 0;
    int errors = 0;
    int          addr_q [$];
    logic [11:0] disp_q [$];

    line_buff_sys dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .pxl_cntr_i   (pxl),
        .ln_cntr_i    (ln),
        .fbuff_data_i (fdata),
        .fbuff_addr_o (faddr),
        .fbuff_en_o   (fen),
        .disp_pxl_o   (disp),
        .fill_busy_o  (busy)
`ifdef UNDERRUN_FLAG_EN
        ,
        .underrun_o   (underrun)
`endif
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [11:0] col(input int r, input int t);
        return 12'((r * 160 + t) * 273 + r);
    endfunction

    function automatic logic [59:0] word(input int a);
        logic [59:0] w;
        for (int j = 0; j < 5; j++) w[j*12 +: 12] = col(a / 32, (a % 32) * 5 + j);
        return w;
    endfunction

    always @(posedge clk_i) if (fen) fdata <= word(int'(faddr));

    task automatic run_fill(input int tln, input int tpx, input int base, input int nwords,
                            input int window, input int exp_busy, input int drop_ln, input string name);
        int busy_cnt = 0;
        int exp_a;
        for (int i = 0; i < nwords; i++) addr_q.push_back(base + i);
        ln = 10'(tln); pxl = 10'(tpx);
        @(posedge clk_i); #1;
        ln = NL; pxl = NP;
        for (int i = 0; i < window; i++) begin
            @(negedge clk_i);
            if (busy) busy_cnt++;
            if (fen) begin
                checks++;
                if (addr_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s_addr unexpected read addr %0d, none required", name, faddr);
                end else begin
                    exp_a = addr_q.pop_front();
                    if (int'(faddr) !== exp_a) begin
                        errors++;
                        $display("FAIL %s_addr got %0d required %0d", name, faddr, exp_a);
                    end
                end
            end
            if (drop_ln != 0 && i == 5) begin ln = 10'(drop_ln); pxl = 0; end
            if (drop_ln != 0 && i == 6) begin ln = NL; pxl = NP; end
        end
        checks++;
        if (busy_cnt !== exp_busy) begin
            errors++;
            $display("FAIL %s_busy got %0d cycles required %0d", name, busy_cnt, exp_busy);
        end
        checks++;
        if (addr_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing got %0d unissued addresses required 0", name, addr_q.size());
        end
        addr_q.delete();
    endtask

    task automatic check_disp(input int l, input int p, input logic [11:0] e, input string name);
        logic [11:0] exp_p;
        disp_q.push_back(e);
        ln = 10'(l); pxl = 10'(p);
        @(negedge clk_i);
        exp_p = disp_q.pop_front();
        checks++;
        if (disp !== exp_p) begin
            errors++;
            $display("FAIL %s ln%0d px%0d got %h required %h", name, l, p, disp, exp_p);
        end
    endtask

    task automatic test_reset;
        rst_i = 1'b1; ln = 35; pxl = 144;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        checks += 4;
        if (fen !== 1'b0)    begin errors++; $display("FAIL reset_en got %b required 0", fen); end
        if (faddr !== 12'd0) begin errors++; $display("FAIL reset_addr got %0d required 0", faddr); end
        if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got %b required 0", busy); end
        if (disp !== 12'd0)  begin errors++; $display("FAIL reset_disp got %h required 000", disp); end
`ifdef UNDERRUN_FLAG_EN
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b required 0", underrun); end
`endif
        @(posedge clk_i); #1;
        rst_i = 1'b0; ln = NL; pxl = NP;
    endtask

    task automatic test_display;
        check_disp(35, 144, col(0, 0), "disp_t0_first");
        check_disp(35, 147, col(0, 0), "disp_t0_last");
        check_disp(35, 148, col(0, 1), "disp_t1");
        check_disp(35, 143, 12'h000, "disp_left_blank");
        check_disp(38, 783, col(0, 159), "disp_t159");
        check_disp(38, 784, 12'h000, "disp_right_blank");
        check_disp(34, 200, 12'h000, "disp_top_blank");
        check_disp(39, 144, col(1, 0), "disp_line1");
        check_disp(42, 150, col(1, 1), "disp_line1_t1");
        check_disp(515, 144, 12'h000, "disp_bottom_blank");
    endtask

    task automatic test_reset_mid_fill;
        int en_cnt = 0;
        ln = 507; pxl = 0;
        @(posedge clk_i); #1;
        ln = 514; pxl = 780;
        repeat (10) @(negedge clk_i);
        checks += 2;
        if (fen !== 1'b1) begin errors++; $display("FAIL midfill_en got %b required 1", fen); end
        if (disp !== col(119, 159)) begin errors++; $display("FAIL midfill_disp got %h required %h", disp, col(119, 159)); end
        #2 rst_i = 1'b1;
        #1;
        checks += 4;
        if (fen !== 1'b0)    begin errors++; $display("FAIL rstmid_en got %b required 0", fen); end
        if (faddr !== 12'd0) begin errors++; $display("FAIL rstmid_addr got %0d required 0", faddr); end
        if (busy !== 1'b0)   begin errors++; $display("FAIL rstmid_busy got %b required 0", busy); end
        if (disp !== 12'd0)  begin errors++; $display("FAIL rstmid_disp got %h required 000", disp); end
        @(posedge clk_i); #1;
        rst_i = 1'b0; ln = NL; pxl = NP;
        repeat (60) begin
            @(negedge clk_i);
            if (fen) en_cnt++;
        end
        checks++;
        if (en_cnt !== 0) begin errors++; $display("FAIL rstmid_no_resume got %0d reads required 0", en_cnt); end
    endtask

`ifdef UNDERRUN_FLAG_EN
    task automatic test_underrun;
        rst_i = 1'b1; ln = 34; pxl = 500;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_pre got %b required 0", underrun); end
        ln = 35; pxl = 144;
        @(posedge clk_i); #1;
        ln = NL; pxl = NP;
        @(negedge clk_i);
        checks++;
        if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_set got %b required 1", underrun); end
        repeat (5) @(negedge clk_i);
        checks++;
        if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_sticky got %b required 1", underrun); end
    endtask
`endif

    initial begin
        rst_i = 1'b1; ln = NL; pxl = NP;
        test_reset();
        run_fill(0, 0, 0, 64, 80, 66, 0, "prefill");
        test_display();
        run_fill(39, 0, 64, 32, 45, 33, 0, "refill");
        check_disp(39, 144, col(1, 0), "refill_line1_kept");
        check_disp(43, 144, col(2, 0), "refill_line2");
        check_disp(46, 160, col(2, 4), "refill_line2_t4");
        run_fill(47, 0, 128, 32, 45, 33, 51, "drop");
        check_disp(51, 144, col(4, 0), "drop_line4");
        check_disp(55, 144, col(1, 0), "drop_stale_line5");
        run_fill(507, 0, 3808, 32, 45, 33, 0, "last_fill");
        for (int p = 780; p < 784; p++) check_disp(514, p, col(119, 159), "last_tile");
        check_disp(511, 144, col(119, 0), "last_line_t0");
        run_fill(511, 0, 0, 0, 45, 0, 0, "no_fill_k119");
        test_reset_mid_fill();
        run_fill(0, 0, 0, 64, 80, 66, 0, "prefill_after_rst");
`ifdef UNDERRUN_FLAG_EN
        test_underrun();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
